// File: rtl/sr_chk_pkg.sv
// Shared types and helpers for the SR latch checker: model state, decoded
// command, and the saturating increment used by every event counter.
package sr_chk_pkg;

  typedef enum logic [1:0] {
    UNINIT = 2'd0,
    VALID  = 2'd1,
    UNDEF  = 2'd2
  } model_state_e;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    SET     = 2'd1,
    CLEAR   = 2'd2,
    ILLEGAL = 2'd3
  } cmd_e;

  typedef struct packed {
    model_state_e st;
    logic         exp;
  } model_t;

  localparam model_t MODEL_RST = '{st: UNINIT, exp: 1'b0};

  // The 33-bit sum keeps the saturation test exact for every max value.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [1:0]  amt,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, val} + {31'b0, amt};
    return (sum > {1'b0, max}) ? max : sum[31:0];
  endfunction

endpackage

// File: rtl/sr_chk_sat_counter.sv
// CNT_W-wide event counter that adds 0..2 per cycle and holds at all-ones.
module sr_chk_sat_counter
  import sr_chk_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       inc_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] ONES = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      sum_w;

  always_comb begin
    sum_w = sat_inc(32'(cnt_q), inc_i, 32'(ONES));
    cnt_d = sum_w[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/sr_latch_checker.sv
// Passive monitor for a gated SR latch: decodes sampled commands, runs a
// reference model, compares delayed model against observed q/qn, counts events.
module sr_latch_checker
  import sr_chk_pkg::*;
#(
  parameter int LAT   = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s,
  input  logic             r,
  input  logic             enable,
  input  logic             latch_reset,
  input  logic             q,
  input  logic             qn,
  output logic             exp_q,
  output logic [1:0]       model_state,
  output logic             mismatch,
  output logic             compl_err,
  output logic             illegal,
  output logic             fail,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] set_count,
  output logic [CNT_W-1:0] rst_count
);

  localparam int DLY_D = (LAT > 0) ? LAT : 1;

  cmd_e   cmd;
  model_t model_q, model_d, cmp;
  model_t dly_q [0:DLY_D-1];
  logic   mism_q, mism_d, compl_q, compl_d, ill_q, fail_q, fail_d;

  always_comb begin
    cmd = HOLD;
    if (latch_reset)   cmd = CLEAR;
    else if (!enable)  cmd = HOLD;
    else begin
      unique case ({s, r})
        2'b10:   cmd = SET;
        2'b01:   cmd = CLEAR;
        2'b11:   cmd = ILLEGAL;
        default: cmd = HOLD;
      endcase
    end
  end

  // ILLEGAL only poisons a known value; from UNINIT/UNDEF it changes nothing.
  always_comb begin
    model_d = model_q;
    unique case (cmd)
      SET:     begin model_d.st = VALID; model_d.exp = 1'b1; end
      CLEAR:   begin model_d.st = VALID; model_d.exp = 1'b0; end
      ILLEGAL: if (model_q.st == VALID) model_d.st = UNDEF;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) model_q <= MODEL_RST;
    else       model_q <= model_d;
  end

  // dly_q[i] holds the post-update model from i+1 edges ago.
  generate
    if (LAT > 0) begin : g_dly
      for (genvar i = 0; i < LAT; i++) begin : g_stage
        always_ff @(posedge clk) begin
          if (reset)       dly_q[i] <= MODEL_RST;
          else if (i == 0) dly_q[i] <= model_d;
          else             dly_q[i] <= dly_q[(i > 0) ? i-1 : 0];
        end
      end
      assign cmp = dly_q[LAT-1];
    end else begin : g_nodly
      always_ff @(posedge clk) dly_q[0] <= MODEL_RST;
      assign cmp = model_d;
    end
  endgenerate

  always_comb begin
    mism_d  = (cmp.st == VALID) && (q != cmp.exp);
    compl_d = (cmp.st == VALID) && (qn == q);
    fail_d  = fail_q | mism_d | compl_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mism_q  <= 1'b0;
      compl_q <= 1'b0;
      ill_q   <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      mism_q  <= mism_d;
      compl_q <= compl_d;
      ill_q   <= (cmd == ILLEGAL);
      fail_q  <= fail_d;
    end
  end

  sr_chk_sat_counter #(.CNT_W(CNT_W)) u_set_cnt (
    .clk(clk), .reset(reset),
    .inc_i({1'b0, cmd == SET}), .count_o(set_count)
  );

  sr_chk_sat_counter #(.CNT_W(CNT_W)) u_rst_cnt (
    .clk(clk), .reset(reset),
    .inc_i({1'b0, cmd == CLEAR}), .count_o(rst_count)
  );

  sr_chk_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk(clk), .reset(reset),
    .inc_i({1'b0, mism_d} + {1'b0, compl_d}), .count_o(err_count)
  );

  assign exp_q       = model_q.exp;
  assign model_state = model_q.st;
  assign mismatch    = mism_q;
  assign compl_err   = compl_q;
  assign illegal     = ill_q;
  assign fail        = fail_q;

endmodule

// File: tb/tb_sr_latch_checker.sv
// Directed bench: two checker instances (CNT_W=8 and CNT_W=2, both LAT=1)
// watch the same stimulus; expected values are hand-computed per step.
module tb_sr_latch_checker;

  logic clk = 1'b0;
  logic reset, s, r, enable, latch_reset, q, qn;

  logic       a_exp_q, a_mism, a_compl, a_ill, a_fail;
  logic [1:0] a_st;
  logic [7:0] a_err, a_set, a_rst;
  logic       b_exp_q, b_mism, b_compl, b_ill, b_fail;
  logic [1:0] b_st;
  logic [1:0] b_err, b_set, b_rst;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sr_latch_checker #(.LAT(1), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .s(s), .r(r), .enable(enable),
    .latch_reset(latch_reset), .q(q), .qn(qn),
    .exp_q(a_exp_q), .model_state(a_st), .mismatch(a_mism),
    .compl_err(a_compl), .illegal(a_ill), .fail(a_fail),
    .err_count(a_err), .set_count(a_set), .rst_count(a_rst)
  );

  sr_latch_checker #(.LAT(1), .CNT_W(2)) u_b (
    .clk(clk), .reset(reset), .s(s), .r(r), .enable(enable),
    .latch_reset(latch_reset), .q(q), .qn(qn),
    .exp_q(b_exp_q), .model_state(b_st), .mismatch(b_mism),
    .compl_err(b_compl), .illegal(b_ill), .fail(b_fail),
    .err_count(b_err), .set_count(b_set), .rst_count(b_rst)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Inputs: en, lr, s, r, q, qn; applied, then one edge, then sampled at +1.
  task automatic cyc(input logic en_, lr_, s_, r_, q_, qn_);
    enable = en_; latch_reset = lr_; s = s_; r = r_; q = q_; qn = qn_;
    @(posedge clk);
    #1;
  endtask

  // Full output snapshot of instance A.
  task automatic chk_a(input string tag, input logic [1:0] st, input logic e,
                       input logic mi, input logic co, input logic il, input logic fa,
                       input logic [7:0] er, input logic [7:0] se, input logic [7:0] rs);
    chk({tag, ".state"}, 32'(a_st), 32'(st));
    chk({tag, ".exp_q"}, 32'(a_exp_q), 32'(e));
    chk({tag, ".mismatch"}, 32'(a_mism), 32'(mi));
    chk({tag, ".compl_err"}, 32'(a_compl), 32'(co));
    chk({tag, ".illegal"}, 32'(a_ill), 32'(il));
    chk({tag, ".fail"}, 32'(a_fail), 32'(fa));
    chk({tag, ".err_count"}, 32'(a_err), 32'(er));
    chk({tag, ".set_count"}, 32'(a_set), 32'(se));
    chk({tag, ".rst_count"}, 32'(a_rst), 32'(rs));
  endtask

  initial begin
    reset = 1'b1;
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk_a("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset.b_set", 32'(b_set), 0);

    reset = 1'b0;
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 1, 1);
    chk_a("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    cyc(0, 1, 0, 0, 0, 1);
    chk_a("lr_clear", 1, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 1, 0, 0, 1);
    chk_a("set", 1, 1, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 0);
    chk_a("q_follows", 1, 1, 0, 0, 0, 0, 0, 1, 1);

    cyc(0, 0, 0, 0, 0, 1);
    chk_a("wrong_q", 1, 1, 1, 0, 0, 1, 1, 1, 1);
    cyc(0, 0, 0, 0, 1, 0);
    chk_a("fail_sticky", 1, 1, 0, 0, 0, 1, 1, 1, 1);

    cyc(1, 0, 1, 1, 1, 0);
    chk_a("illegal1", 2, 1, 0, 0, 1, 1, 1, 1, 1);
    cyc(1, 0, 1, 1, 0, 0);
    chk_a("illegal2", 2, 1, 0, 0, 1, 1, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk_a("undef_hold", 2, 1, 0, 0, 0, 1, 1, 1, 1);
    cyc(1, 0, 0, 1, 1, 1);
    chk_a("undef_clear", 1, 0, 0, 0, 0, 1, 1, 1, 2);
    cyc(1, 1, 1, 1, 0, 1);
    chk_a("lr_over_ill", 1, 0, 0, 0, 0, 1, 1, 1, 3);

    cyc(1, 0, 1, 0, 0, 1);
    cyc(1, 0, 1, 0, 1, 0);
    chk("sat2.b_set", 32'(b_set), 3);
    cyc(1, 0, 1, 0, 1, 0);
    cyc(1, 0, 1, 0, 1, 0);
    cyc(1, 0, 1, 0, 1, 0);
    chk("sat5.b_set", 32'(b_set), 3);
    chk("sat5.b_rst", 32'(b_rst), 3);
    chk_a("five_sets", 1, 1, 0, 0, 0, 1, 1, 6, 3);

    cyc(0, 0, 0, 0, 1, 1);
    chk_a("compl", 1, 1, 0, 1, 0, 1, 2, 6, 3);
    chk("compl.b_err", 32'(b_err), 2);
    cyc(0, 0, 0, 0, 1, 0);
    chk("compl_off", 32'(a_compl), 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk_a("both", 1, 1, 1, 1, 0, 1, 4, 6, 3);
    chk("both.b_err_sat", 32'(b_err), 3);
    chk("both.b_fail", 32'(b_fail), 1);

    reset = 1'b1;
    cyc(1, 0, 1, 0, 0, 1);
    chk_a("mid_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("mid_reset.b_err", 32'(b_err), 0);
    reset = 1'b0;
    cyc(0, 0, 0, 0, 1, 1);
    chk_a("post_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_reset.b_mism", 32'(b_mism), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
